// File: rtl/aes_spi_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_spi_cmd_ctrl
// Purpose  : SPI command/data controller feeding an AES-128 CBC core: decodes
//            command frames, assembles key/IV/plaintext, serves ciphertext.
// Revision : 1.0  initial release
// ============================================================================
module aes_spi_cmd_ctrl #(
    parameter int         BLK_BYTES = 16,
    parameter logic [7:0] CMD_PT    = 8'h01,
    parameter logic [7:0] CMD_KEY   = 8'h02,
    parameter logic [7:0] CMD_IV    = 8'h03,
    parameter logic [7:0] CMD_NEXT  = 8'h04,
    parameter logic [7:0] CMD_READ  = 8'h05,
    parameter logic [7:0] CMD_FIRST = 8'h06
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ss_active,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_byte,
    input  logic                   tx_ready,
    output logic [7:0]             tx_byte,
    output logic                   tx_load,
    output logic [8*BLK_BYTES-1:0] key,
    output logic [8*BLK_BYTES-1:0] iv,
    output logic [8*BLK_BYTES-1:0] pt,
    output logic                   start_first,
    output logic                   start_next,
    input  logic                   aes_busy,
    input  logic                   aes_done,
    input  logic [8*BLK_BYTES-1:0] ct_in,
    output logic                   ct_valid,
    output logic                   err
);

    localparam int               c_blk_bits = 8 * BLK_BYTES;
    localparam int               c_cnt_w    = $clog2(BLK_BYTES + 1);
    localparam logic [c_cnt_w-1:0] c_full   = c_cnt_w'(BLK_BYTES);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_LOAD = 2'd2,
        S_READ = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        T_PT  = 2'd0,
        T_KEY = 2'd1,
        T_IV  = 2'd2
    } target_t;

    state_t                r_state;
    state_t                w_state_nxt;
    target_t               r_target;
    logic                  r_ss;
    logic                  r_ss_d;
    logic                  w_frame_start;
    logic                  w_frame_end;
    logic [7:0]            r_cmd;
    logic                  r_cmd_seen;
    logic [c_blk_bits-1:0] r_shadow;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_commit;
    logic [c_blk_bits-1:0] r_key;
    logic [c_blk_bits-1:0] r_iv;
    logic [c_blk_bits-1:0] r_pt;
    logic [c_blk_bits-1:0] r_ct;
    logic                  r_ct_valid;
    logic [c_blk_bits-1:0] r_txsh;
    logic [c_cnt_w-1:0]    r_sent;
    logic [7:0]            r_tx_byte;
    logic                  r_tx_load;
    logic                  r_err;
    logic                  w_start_first;
    logic                  w_start_next;
    logic                  w_start;

    // Edges come from a two-stage history of the already-synchronized select.
    assign w_frame_start = r_ss & ~r_ss_d;
    assign w_frame_end   = ~r_ss & r_ss_d;
    assign w_start       = w_start_first | w_start_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start_first = 1'b0;
        w_start_next  = 1'b0;
        case (r_state)
            S_IDLE: if (w_frame_end) w_state_nxt = S_CMD;
            S_CMD: begin
                w_state_nxt = S_IDLE;
                case (r_cmd)
                    CMD_PT, CMD_KEY, CMD_IV: w_state_nxt = S_LOAD;
                    CMD_FIRST: w_start_first = ~aes_busy;
                    CMD_NEXT:  w_start_next  = ~aes_busy;
                    CMD_READ:  if (r_ct_valid) w_state_nxt = S_READ;
                    default:   w_state_nxt = S_IDLE;
                endcase
            end
            // An empty data frame does not cancel the pending load.
            S_LOAD: if (w_frame_end && (r_cnt != '0)) w_state_nxt = S_IDLE;
            S_READ: if (w_frame_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ss       <= 1'b0;
            r_ss_d     <= 1'b0;
            r_target   <= T_PT;
            r_cmd      <= '0;
            r_cmd_seen <= 1'b0;
            r_shadow   <= '0;
            r_cnt      <= '0;
            r_commit   <= 1'b0;
            r_key      <= '0;
            r_iv       <= '0;
            r_pt       <= '0;
            r_ct       <= '0;
            r_ct_valid <= 1'b0;
            r_txsh     <= '0;
            r_sent     <= '0;
            r_tx_byte  <= '0;
            r_tx_load  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ss      <= ss_active;
            r_ss_d    <= r_ss;
            r_tx_load <= 1'b0;
            r_commit  <= 1'b0;

            if (r_commit) begin
                case (r_target)
                    T_KEY:   r_key <= r_shadow;
                    T_IV:    r_iv  <= r_shadow;
                    default: r_pt  <= r_shadow;
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    if (rx_valid && !r_cmd_seen) begin
                        r_cmd      <= rx_byte;
                        r_cmd_seen <= 1'b1;
                    end
                end
                S_CMD: begin
                    // Clearing the opcode makes an empty command frame an error.
                    r_cmd      <= '0;
                    r_cmd_seen <= 1'b0;
                    case (r_cmd)
                        CMD_PT, CMD_KEY, CMD_IV: begin
                            r_target <= (r_cmd == CMD_KEY) ? T_KEY :
                                        (r_cmd == CMD_IV)  ? T_IV  : T_PT;
                            r_cnt    <= '0;
                            r_shadow <= '0;
                            r_err    <= 1'b0;
                        end
                        CMD_FIRST, CMD_NEXT: if (aes_busy) r_err <= 1'b1;
                        CMD_READ: begin
                            r_sent <= c_full;
                            if (!r_ct_valid) r_err <= 1'b1;
                        end
                        default: r_err <= 1'b1;
                    endcase
                end
                S_LOAD: begin
                    if (rx_valid && (r_cnt != c_full)) begin
                        r_shadow <= {r_shadow[c_blk_bits-9:0], rx_byte};
                        r_cnt    <= r_cnt + c_one;
                        if (r_cnt == (c_full - c_one)) r_commit <= 1'b1;
                    end
                    if (w_frame_end && (r_cnt != '0) && (r_cnt != c_full)) r_err <= 1'b1;
                end
                S_READ: begin
                    if (w_frame_start) begin
                        r_tx_byte <= r_ct[c_blk_bits-1 -: 8];
                        r_txsh    <= r_ct << 8;
                        r_sent    <= c_one;
                        r_tx_load <= 1'b1;
                    end else if (tx_ready) begin
                        if (r_sent != c_full) begin
                            r_tx_byte <= r_txsh[c_blk_bits-1 -: 8];
                            r_txsh    <= r_txsh << 8;
                            r_sent    <= r_sent + c_one;
                            r_tx_load <= 1'b1;
                        end else begin
                            r_tx_byte <= 8'h00;
                        end
                    end
                end
                default: ;
            endcase

            // A new start invalidates the result even if a capture lands alongside.
            if (aes_done) r_ct <= ct_in;
            if (w_start) begin
                r_ct_valid <= 1'b0;
            end else if (aes_done) begin
                r_ct_valid <= 1'b1;
            end
        end
    end

    assign key         = r_key;
    assign iv          = r_iv;
    assign pt          = r_pt;
    assign tx_byte     = r_tx_byte;
    assign tx_load     = r_tx_load;
    assign start_first = w_start_first;
    assign start_next  = w_start_next;
    assign ct_valid    = r_ct_valid;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_spi_cmd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aes_spi_cmd_ctrl
// Purpose  : Directed + randomized bench for aes_spi_cmd_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_aes_spi_cmd_ctrl;

    typedef logic [7:0] bq_t [$];

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ss_active = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_byte = 8'h00;
    logic         tx_ready = 1'b0;
    logic         aes_busy = 1'b0;
    logic         aes_done = 1'b0;
    logic [127:0] ct_in = '0;
    logic [7:0]   tx_byte;
    logic         tx_load;
    logic [127:0] key, iv, pt;
    logic         start_first, start_next, ct_valid, err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [127:0] m_key = '0, m_iv = '0, m_pt = '0, m_ct = '0;
    bit           m_ctv = 1'b0, m_err = 1'b0;

    aes_spi_cmd_ctrl dut (
        .clk(clk), .rst(rst), .ss_active(ss_active), .rx_valid(rx_valid),
        .rx_byte(rx_byte), .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_load(tx_load),
        .key(key), .iv(iv), .pt(pt), .start_first(start_first), .start_next(start_next),
        .aes_busy(aes_busy), .aes_done(aes_done), .ct_in(ct_in),
        .ct_valid(ct_valid), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic frame(input bq_t b);
        ss_active = 1'b1;
        repeat (3) tick();
        foreach (b[i]) begin
            rx_byte  = b[i];
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        tick();
        ss_active = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] c);
        bq_t q;
        int  nf = 0, nn = 0, off = -1;
        bit  expf = 1'b0, expn = 1'b0;
        q.push_back(c);
        frame(q);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (start_first) begin nf++; if (off < 0) off = i; end
            if (start_next)  begin nn++; if (off < 0) off = i; end
        end
        case (c)
            8'h01, 8'h02, 8'h03: m_err = 1'b0;
            8'h04, 8'h06: begin
                if (aes_busy) m_err = 1'b1;
                else begin
                    expf  = (c == 8'h06);
                    expn  = (c == 8'h04);
                    m_ctv = 1'b0;
                end
            end
            8'h05:   if (!m_ctv) m_err = 1'b1;
            default: m_err = 1'b1;
        endcase
        chk($sformatf("cmd%02h_first_pulses", c), 128'(nf), 128'(expf));
        chk($sformatf("cmd%02h_next_pulses", c), 128'(nn), 128'(expn));
        if (expf || expn) chk($sformatf("cmd%02h_pulse_latency", c), 128'(off), 128'(2));
        chk($sformatf("cmd%02h_err", c), 128'(err), 128'(m_err));
        chk($sformatf("cmd%02h_ct_valid", c), 128'(ct_valid), 128'(m_ctv));
    endtask

    task automatic load(input logic [7:0] c, input logic [127:0] data, input int n);
        bq_t q;
        cmd(c);
        for (int i = 0; i < n; i++) begin
            if (i < 16) q.push_back(data[127-8*i -: 8]);
            else        q.push_back(8'($urandom));
        end
        frame(q);
        repeat (6) tick();
        if (n >= 16) begin
            case (c)
                8'h02:   m_key = data;
                8'h03:   m_iv  = data;
                default: m_pt  = data;
            endcase
        end else if (n > 0) begin
            m_err = 1'b1;
        end
        chk($sformatf("load%02h_n%0d_key", c, n), key, m_key);
        chk($sformatf("load%02h_n%0d_iv", c, n), iv, m_iv);
        chk($sformatf("load%02h_n%0d_pt", c, n), pt, m_pt);
        chk($sformatf("load%02h_n%0d_err", c, n), 128'(err), 128'(m_err));
    endtask

    task automatic core_done(input logic [127:0] ct);
        aes_done = 1'b1;
        ct_in    = ct;
        tick();
        aes_done = 1'b0;
        ct_in    = rnd128();
        m_ct     = ct;
        m_ctv    = 1'b1;
        tick();
        chk("done_ct_valid", 128'(ct_valid), 128'(m_ctv));
    endtask

    task automatic read_check(input string tag);
        logic [127:0] got = '0;
        int           w, tmo = 0, extra = 0;
        ss_active = 1'b1;
        w = 0;
        while (!tx_load && w < 10) begin tick(); w++; end
        if (!tx_load) tmo++;
        got = {got[119:0], tx_byte};
        for (int i = 1; i < 16; i++) begin
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
            w = 0;
            while (!tx_load && w < 5) begin tick(); w++; end
            if (!tx_load) tmo++;
            got = {got[119:0], tx_byte};
        end
        chk({tag, "_timeouts"}, 128'(tmo), 128'(0));
        chk({tag, "_bytes"}, got, m_ct);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            extra += int'(tx_load);
            tick();
        end
        chk({tag, "_tail_loads"}, 128'(extra), 128'(0));
        chk({tag, "_tail_byte"}, 128'(tx_byte), 128'(0));
        ss_active = 1'b0;
        repeat (6) tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_key"}, key, '0);
        chk({tag, "_iv"}, iv, '0);
        chk({tag, "_pt"}, pt, '0);
        chk({tag, "_tx_byte"}, 128'(tx_byte), '0);
        chk({tag, "_strobes"}, 128'({tx_load, start_first, start_next}), '0);
        chk({tag, "_ct_valid"}, 128'(ct_valid), '0);
        chk({tag, "_err"}, 128'(err), '0);
    endtask

    initial begin
        int nl;
        #2 rst = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b1;
        tick();

        load(8'h02, 128'h00112233445566778899AABBCCDDEEFF, 16);
        load(8'h03, 128'hAABBCCDDEEFF00112233445566778899, 16);

        load(8'h01, 128'hd1cddc70c7720d9aafac5065a84ea579, 16);
        cmd(8'h06);
        core_done(128'h9782B8E6186C948BCAA6FB177449444E);
        cmd(8'h05);
        read_check("read1");
        cmd(8'h05);
        read_check("read2");

        load(8'h01, 128'haa884e36768f1d178ae26cbdfbe938cd, 16);
        cmd(8'h04);
        core_done(128'hBECCCAF9D1BB403F5F76EF6E24CF92AB);
        cmd(8'h05);
        read_check("read_chain");

        for (int r = 0; r < 4; r++) begin
            load(8'h01, rnd128(), 16 + int'($urandom_range(0, 2)));
            cmd(($urandom % 2) ? 8'h06 : 8'h04);
            core_done(rnd128());
            cmd(8'h05);
            read_check($sformatf("read_rnd%0d", r));
        end

        // Error paths
        cmd(8'h06);
        cmd(8'h05);
        nl = 0;
        ss_active = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(); nl += int'(tx_load); end
        ss_active = 1'b0;
        repeat (6) tick();
        m_err = 1'b1;
        chk("read_invalid_loads", 128'(nl), 128'(0));
        chk("read_invalid_err", 128'(err), 128'(m_err));
        load(8'h01, rnd128(), 16);
        aes_busy = 1'b1;
        cmd(8'h06);
        aes_busy = 1'b0;
        load(8'h01, rnd128(), 16);
        load(8'h02, rnd128(), 10);
        load(8'h01, rnd128(), 16);
        cmd(8'h7F);
        load(8'h01, rnd128(), 16);

        // Reset in the middle of a plaintext frame
        cmd(8'h01);
        ss_active = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            rx_byte  = 8'($urandom);
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            tick();
        end
        rst = 1'b0;
        #1;
        check_zero("rst_mid");
        ss_active = 1'b0;
        m_key = '0; m_iv = '0; m_pt = '0; m_ct = '0; m_ctv = 1'b0; m_err = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        check_zero("rst_rel");
        load(8'h01, rnd128(), 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_spi_cmd_ctrl.md
Name: aes_spi_cmd_ctrl

Overview:
- Command/data controller between the SPI byte shifter (upstream) and the AES-128 CBC core (downstream) inside aes_top.
- Decodes one-byte command frames and assembles 16-byte frames into the key, IV or plaintext registers.
- Issues encryption start pulses, captures the core's ciphertext, and serves it back byte-serially, MSB first.

Parameters:
- BLK_BYTES, 16, bytes per data frame (block = 8*BLK_BYTES bits).
- CMD_PT, 8'h01, load plaintext.
- CMD_KEY, 8'h02, load key.
- CMD_IV, 8'h03, load IV.
- CMD_NEXT, 8'h04, encrypt chained block.
- CMD_READ, 8'h05, read ciphertext.
- CMD_FIRST, 8'h06, encrypt first block (IV-seeded).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ss_active  in  1  SPI select, already synchronized; 1 = frame in progress.
- rx_valid  in  1  one-cycle strobe: rx_byte holds a completed MOSI byte.
- rx_byte  in  8  received byte.
- tx_ready  in  1  one-cycle strobe: shifter has taken tx_byte and wants the next byte.
- tx_byte  out  8  byte to shift out on MISO.
- tx_load  out  1  one-cycle strobe: tx_byte is valid.
- key  out  128  key register.
- iv  out  128  IV register.
- pt  out  128  plaintext register.
- start_first  out  1  one-cycle pulse to the core.
- start_next  out  1  one-cycle pulse to the core.
- aes_busy  in  1  core is processing.
- aes_done  in  1  one-cycle pulse: ct_in is valid.
- ct_in  in  128  core result.
- ct_valid  out  1  ciphertext register holds an unread-or-read valid result.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst=0, async): all outputs, registers, counters = 0; state = IDLE.
- Frame edges: ss_active is registered; frame_start = 0→1 edge, frame_end = 1→0 edge, each detected one cycle after the change.
- State IDLE:
  - First rx_valid in a frame latches cmd; later bytes in that frame are ignored.
  - At frame_end, go to CMD.
- State CMD (single cycle). Action depends on cmd:
  - 01/02/03: target := pt/key/iv; byte count := 0; go to LOAD. err cleared.
  - 06 (CMD_FIRST): if !aes_busy, start_first = 1 this cycle and ct_valid := 0; otherwise err := 1. Go to IDLE.
  - 04 (CMD_NEXT): same as 06 but pulses start_next.
  - 05 (CMD_READ): if ct_valid, go to READ with byte index 15; otherwise err := 1 and go to IDLE.
  - Any other value: err := 1; go to IDLE.
  - Net latency: start pulse appears 2 cycles after ss_active falls.
- State LOAD:
  - Each rx_valid shifts rx_byte into a 128-bit shadow from the LSB end; the first byte ends up as shadow[127:120].
  - On the 16th byte, the shadow is committed to the target on the following cycle. Bytes beyond 16 are ignored.
  - At frame_end: go to IDLE. If fewer than 16 bytes arrived, the target is unchanged and err := 1.
  - A frame_end with zero bytes keeps the state in LOAD; the data frame may follow later.
- State READ:
  - At frame_start, tx_byte := ct_reg[127:120] and tx_load pulses one cycle later.
  - Each tx_ready advances the index by one byte, then tx_byte/tx_load update on the next cycle.
  - After 16 bytes, tx_byte = 8'h00 (no further tx_load).
  - At frame_end, go to IDLE. ct_reg is retained, so a repeated read is allowed.
- Ciphertext capture: aes_done (sampled in any state) sets ct_reg := ct_in and ct_valid := 1. If aes_done and a start occur in the same cycle, capture wins ct_reg, and ct_valid ends at 0 because of the new start.
- Register stability: key/iv/pt change only at commit. A commit while aes_busy is allowed; the core must latch its inputs at start.
- Frame aborts:
  - ss_active dropping mid-byte: no rx_valid, so the partial byte is lost.
  - ss_active rising while in CMD: the frame_start is handled in the next state.
- Reset mid-frame discards everything, including the shadow register.

Test Plan:
- Key and IV load: cmd 02 frame, then 16-byte frame 00112233445566778899AABBCCDDEEFF → key = that value. Then cmd 03 + AABBCCDDEEFF00112233445566778899 → iv matches; err = 0.
- First encrypt:
  - Stimulus: cmd 01 + d1cddc70c7720d9aafac5065a84ea579, then cmd 06.
  - Response: start_first pulses exactly once, 2 cycles after ss_active falls.
  - Then model aes_done with ct_in 9782B8E6186C948BCAA6FB177449444E → ct_valid = 1.
- Read back: cmd 05, then a 16-byte read frame → tx_byte sequence 97,82,B8,…,4E. A 17th tx_ready gives 00. A second read frame repeats the same bytes.
- Chained encrypt: cmd 01 + aa884e36768f1d178ae26cbdfbe938cd, then cmd 04 → start_next pulse and ct_valid drops to 0. aes_done with BECCCAF9D1BB403F5F76EF6E24CF92AB → readback matches.
- Errors:
  - cmd 05 with ct_valid = 0 → err = 1, no tx_load.
  - cmd 06 while aes_busy = 1 → no pulse, err = 1.
  - cmd 02 then a 10-byte frame → key unchanged, err = 1.
  - cmd 7F → err = 1.
  - A following valid cmd 01 clears err.
- Reset: assert rst low midway through a 16-byte plaintext frame → all outputs 0 immediately; after release, a fresh cmd 01 frame works normally.
